fios_result_collector: RTL

- Downstream consumer of the last DSP stage in the 4A cascaded FIOS Montgomery multiplier.
- Accepts the 34-bit P output stream of that stage, one partial word per valid cycle.
- Resolves carries between 17-bit limbs and deserializes the limbs into a full S-word result register.
- Presents the result to the next consumer through a valid/ready handshake.

---
 rtl/fios_result_collector.sv | 102 ++++++++++
 1 files changed

// File: rtl/fios_result_collector.sv
// Collects the 34-bit P stream of the last FIOS DSP stage. It resolves the limb carries
// into an S x 17-bit result and hands that result out through a valid/ready handshake.
// Optional build macro FIOS_COLLECT_OVF_EN adds ovf_o, which flags a final carry wider than 17 bits.
module fios_result_collector #(
  parameter int S    = 16,
  parameter int WORD = 17
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                start_i,
  input  logic                p_valid_i,
  input  logic [2*WORD-1:0]   P_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
`ifdef FIOS_COLLECT_OVF_EN
  output logic                ovf_o,
`endif
  output logic [S*WORD-1:0]   res_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(S);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORD:0]      r_carry;
  logic [S*WORD-1:0]  r_res;
  logic [2*WORD:0]    w_sum;
  logic               w_accept;
  logic               w_last;
  logic               w_init;

  // The carry stays below 2^17+2, so an 18-bit register never wraps.
  assign w_sum    = {1'b0, P_i} + {{WORD{1'b0}}, r_carry};
  assign w_accept = (r_state == COLLECT) && p_valid_i;
  assign w_last   = w_accept && (r_cnt == CNT_W'(S - 2));
  assign w_init   = start_i && ((r_state == IDLE) ||
                                ((r_state == HOLD) && res_ready_i));

  always_comb begin
    // NOTE: default first, so that no path through the case statement infers a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next_state = COLLECT;
      COLLECT: if (w_last)  w_next_state = FLUSH;
      FLUSH:   w_next_state = HOLD;
      HOLD:    if (res_ready_i) w_next_state = start_i ? COLLECT : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= '0;
      // NOTE: the result register is reset explicitly because res_o must read 0 out of reset.
      r_res   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_init) begin
        r_cnt   <= '0;
        r_carry <= '0;
        r_res   <= '0;
      end else if (w_accept) begin
        for (int k = 0; k < S - 1; k++) begin
          if (r_cnt == CNT_W'(k)) r_res[k*WORD +: WORD] <= w_sum[WORD-1:0];
        end
        r_carry <= w_sum[2*WORD:WORD];
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (r_state == FLUSH) begin
        r_res[(S-1)*WORD +: WORD] <= r_carry[WORD-1:0];
      end
    end
  end

`ifdef FIOS_COLLECT_OVF_EN
  logic r_ovf;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)               r_ovf <= 1'b0;
    else if (w_init)              r_ovf <= 1'b0;
    else if (r_state == FLUSH)    r_ovf <= r_carry[WORD];
  end

  assign ovf_o = r_ovf;
`endif

  assign res_o       = r_res;
  assign res_valid_o = (r_state == HOLD);
  assign busy_o      = (r_state != IDLE);

endmodule
